// File: rtl/vote_collector_if.sv
// Ballot-in and ballot-set-out handshakes between voters, the collector and the majority evaluator.
interface vote_collector_if;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_id;
    logic       in_ballot;
    logic       out_valid;
    logic       out_ready;
    logic [7:1] vote;
    logic [7:1] voted;
    logic [2:0] yes_count;
    logic       timed_out;
    logic       dup_err;
    logic       id_err;

    modport master (
        output in_valid, in_id, in_ballot, out_ready,
        input  in_ready, out_valid, vote, voted, yes_count, timed_out, dup_err, id_err
    );

    modport slave (
        input  in_valid, in_id, in_ballot, out_ready,
        output in_ready, out_valid, vote, voted, yes_count, timed_out, dup_err, id_err
    );
endinterface

// File: rtl/vote_collector.sv
// Collects serial ballots from voters 1..7 into a parallel vote set and hands it to the
// majority evaluator once every voter has voted or the collection window closes.
module vote_collector #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic            clk,
    input  logic            rst,
    vote_collector_if.slave bus
);
    typedef enum logic [1:0] {IDLE, COLLECT, PRESENT} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] timer;
    logic             accept;
    logic             id_ok;
    logic             dup;
    logic             fresh;
    logic [7:1]       id_bit;
    logic [7:1]       voted_next;

    // Id 0 decodes to an empty mask, so it can never mark a voter.
    function automatic logic [7:1] id_onehot(input logic [2:0] id);
        return 7'((8'd1 << id) >> 1);
    endfunction

    function automatic logic [2:0] add_yes(input logic [2:0] count, input logic ballot);
        return count + {2'b00, ballot};
    endfunction

    assign bus.in_ready  = (state != PRESENT);
    assign bus.out_valid = (state == PRESENT);

    assign accept     = bus.in_valid && bus.in_ready;
    assign id_bit     = id_onehot(bus.in_id);
    assign id_ok      = |id_bit;
    assign dup        = |(bus.voted & id_bit);
    assign fresh      = accept && id_ok && !dup;
    assign voted_next = fresh ? (bus.voted | id_bit) : bus.voted;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            timer         <= '0;
            bus.vote      <= '0;
            bus.voted     <= '0;
            bus.yes_count <= '0;
            bus.timed_out <= 1'b0;
            bus.dup_err   <= 1'b0;
            bus.id_err    <= 1'b0;
        end else begin
            bus.dup_err <= accept && id_ok && dup;
            bus.id_err  <= accept && !id_ok;

            if (fresh) begin
                bus.voted     <= voted_next;
                bus.vote      <= bus.vote | (bus.in_ballot ? id_bit : 7'b0);
                bus.yes_count <= add_yes(bus.yes_count, bus.in_ballot);
            end

            case (state)
                IDLE: begin
                    if (fresh) begin
                        timer <= '0;
                        state <= COLLECT;
                    end
                end
                COLLECT: begin
                    // A completing 7th ballot wins over a coincident expiry.
                    if (voted_next == 7'h7F) begin
                        bus.timed_out <= 1'b0;
                        state         <= PRESENT;
                    end else if (timer == LAST) begin
                        bus.timed_out <= 1'b1;
                        state         <= PRESENT;
                    end else begin
                        timer <= timer + CNT_W'(1);
                    end
                end
                PRESENT: begin
                    if (bus.out_ready) begin
                        timer         <= '0;
                        bus.vote      <= '0;
                        bus.voted     <= '0;
                        bus.yes_count <= '0;
                        bus.timed_out <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
